// File: rtl/accum_alu_if.sv
// Handshake and result bundle between the operand/opcode sequencer and accum_alu.
interface accum_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem;
  logic             done;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, opcode, operand,
    input  in_ready, acc, rem, done, zero, carry, ovf, err
  );

  modport slave (
    input  in_valid, opcode, operand,
    output in_ready, acc, rem, done, zero, carry, ovf, err
  );
endinterface

// File: rtl/accum_alu.sv
// WIDTH-bit accumulator ALU with valid/ready input, done pulse and status flags.
// Define ACCUM_ALU_MULDIV_EN to build the iterative MUL/DIV datapath; otherwise opcodes 3/4 are reserved.
module accum_alu #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  accum_alu_if.slave bus
);
  // state | meaning
  // IDLE  | accepting ops; single-cycle ops complete here
  // MUL   | shift-add multiply, one multiplier bit per cycle
  // DIV   | restoring divide, one quotient bit per cycle

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9;
  localparam logic [3:0] OP_XOR   = 4'd10;
  localparam logic [3:0] OP_NAND  = 4'd11;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_XNOR  = 4'd13;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_CLEAR = 4'd15;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             accept;
  logic             wr;
  logic             cy;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;

`ifdef ACCUM_ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam int         CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_hi, div_lo;

  // Multiply: {hi,lo} starts as {0,acc}; add operand into hi on lo[0], then shift right.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  assign div_diff = div_sh[WIDTH-1:0] - opnd_q;
  assign div_hi   = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_lo   = {lo_q[WIDTH-2:0], div_ge};

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.rem      = rem_q;
  assign bus.ovf      = ovf_q;
`else
  assign bus.in_ready = 1'b1;
  assign bus.rem      = '0;
  assign bus.ovf      = 1'b0;
`endif

  assign accept    = bus.in_valid && bus.in_ready;
  assign add_w     = {1'b0, acc_q} + {1'b0, bus.operand};
  assign sub_w     = {1'b0, acc_q} - {1'b0, bus.operand};
  assign bus.acc   = acc_q;
  assign bus.zero  = zero_q;
  assign bus.carry = carry_q;
  assign bus.err   = err_q;
  assign bus.done  = done_q;

  always_comb begin
    acc_d   = acc_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    err_d   = err_q;
    done_d  = 1'b0;
    wr      = 1'b0;
    res     = acc_q;
    cy      = 1'b0;
`ifdef ACCUM_ALU_MULDIV_EN
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`endif
    if (accept) begin
      done_d = 1'b1;
      case (bus.opcode)
        OP_NOP:   begin end
        OP_ADD:   begin wr = 1'b1; res = add_w[WIDTH-1:0]; cy = add_w[WIDTH]; end
        OP_SUB:   begin wr = 1'b1; res = sub_w[WIDTH-1:0]; cy = sub_w[WIDTH]; end
`ifdef ACCUM_ALU_MULDIV_EN
        OP_MUL: begin
          done_d  = 1'b0;
          state_d = S_MUL;
          cnt_d   = CNT_LAST;
          opnd_d  = bus.operand;
          hi_d    = '0;
          lo_d    = acc_q;
        end
        OP_DIV: begin
          if (bus.operand == '0) begin
            err_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = S_DIV;
            cnt_d   = CNT_LAST;
            opnd_d  = bus.operand;
            hi_d    = '0;
            lo_d    = acc_q;
          end
        end
`endif
        OP_NOT:   begin wr = 1'b1; res = ~acc_q; end
        OP_AND:   begin wr = 1'b1; res = acc_q & bus.operand; end
        OP_OR:    begin wr = 1'b1; res = acc_q | bus.operand; end
        OP_XOR:   begin wr = 1'b1; res = acc_q ^ bus.operand; end
        OP_NAND:  begin wr = 1'b1; res = ~(acc_q & bus.operand); end
        OP_NOR:   begin wr = 1'b1; res = ~(acc_q | bus.operand); end
        OP_XNOR:  begin wr = 1'b1; res = ~(acc_q ^ bus.operand); end
        OP_LOAD:  begin wr = 1'b1; res = bus.operand; end
        OP_CLEAR: begin
          wr    = 1'b1;
          res   = '0;
          err_d = 1'b0;
`ifdef ACCUM_ALU_MULDIV_EN
          rem_d = '0;
`endif
        end
        default:  err_d = 1'b1;
      endcase
      if (wr) begin
        acc_d   = res;
        zero_d  = (res == '0);
        carry_d = cy;
`ifdef ACCUM_ALU_MULDIV_EN
        ovf_d   = 1'b0;
`endif
      end
    end
`ifdef ACCUM_ALU_MULDIV_EN
    else if (state_q != S_IDLE) begin
      cnt_d = cnt_q - 1'b1;
      if (state_q == S_MUL) begin
        hi_d = mul_hi;
        lo_d = mul_lo;
      end else begin
        hi_d = div_hi;
        lo_d = div_lo;
      end
      // cnt_q == 0 marks the last iteration; results land on this edge.
      if (cnt_q == '0) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        carry_d = 1'b0;
        if (state_q == S_MUL) begin
          acc_d  = mul_lo;
          zero_d = (mul_lo == '0);
          ovf_d  = |mul_hi;
        end else begin
          acc_d  = div_lo;
          zero_d = (div_lo == '0);
          rem_d  = div_hi;
          ovf_d  = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef ACCUM_ALU_MULDIV_EN
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`endif
    end else begin
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef ACCUM_ALU_MULDIV_EN
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`endif
    end
  end
endmodule

// File: tb/tb_accum_alu.sv
// Scoreboard bench for accum_alu (WIDTH=8); expectations follow ACCUM_ALU_MULDIV_EN.
module tb_accum_alu;
  localparam int W = 8;
  localparam int LAT1 = 1;
  localparam int LATN = W + 1;

  typedef struct {
    string      tag;
    logic [7:0] acc;
    logic [7:0] rem;
    logic       z, c, o, e;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  int   last_wait = 0;
  exp_t sb_q[$];

  accum_alu_if #(.WIDTH(W)) bus();
  accum_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got %0h want %0h", name, act, exp);
  endfunction

  // Monitor: every done pulse pops one expectation, including its completion cycle.
  always @(negedge clk) begin
    if (rst && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        tot_cnt++;
        $display("FAIL unexpected_done at cycle %0d got done=1 want 0", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, ".cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.tag, ".acc"}, {24'b0, bus.acc}, {24'b0, e.acc});
        check({e.tag, ".rem"}, {24'b0, bus.rem}, {24'b0, e.rem});
        check({e.tag, ".zero"}, {31'b0, bus.zero}, {31'b0, e.z});
        check({e.tag, ".carry"}, {31'b0, bus.carry}, {31'b0, e.c});
        check({e.tag, ".ovf"}, {31'b0, bus.ovf}, {31'b0, e.o});
        check({e.tag, ".err"}, {31'b0, bus.err}, {31'b0, e.e});
      end
    end
  end

  // Called at a falling edge; holds in_valid until accepted, then scrambles the operand.
  task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a, input bit push,
                       input logic [7:0] e_acc, input logic [7:0] e_rem,
                       input logic z, input logic c, input logic o, input logic e, input int lat);
    exp_t x;
    int k;
    last_wait = 0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.operand  = a;
    while (bus.in_ready !== 1'b1 && last_wait < 50) begin
      @(negedge clk);
      last_wait++;
    end
    if (bus.in_ready !== 1'b1) begin
      tot_cnt++;
      $display("FAIL %s.accept_timeout got in_ready=0 want 1", tag);
      bus.in_valid = 1'b0;
      return;
    end
    k = cyc;
    @(posedge clk);
    if (push) begin
      x.tag = tag; x.acc = e_acc; x.rem = e_rem;
      x.z = z; x.c = c; x.o = o; x.e = e; x.cyc = k + lat;
      sb_q.push_back(x);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.opcode   = 4'h0;
    bus.operand  = 8'hA5;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.opcode   = 4'h0;
    bus.operand  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst.acc", {24'b0, bus.acc}, 32'h0);
    check("rst.rem", {24'b0, bus.rem}, 32'h0);
    check("rst.done", {31'b0, bus.done}, 32'h0);
    check("rst.zero", {31'b0, bus.zero}, 32'h1);
    check("rst.carry", {31'b0, bus.carry}, 32'h0);
    check("rst.ovf", {31'b0, bus.ovf}, 32'h0);
    check("rst.err", {31'b0, bus.err}, 32'h0);
    check("rst.in_ready", {31'b0, bus.in_ready}, 32'h1);

    issue("load05", 4'd14, 8'h05, 1, 8'h05, 8'h00, 0, 0, 0, 0, LAT1);
`ifdef ACCUM_ALU_MULDIV_EN
    issue("mul03", 4'd3, 8'h03, 1, 8'h0F, 8'h00, 0, 0, 0, 0, LATN);
    check("mul03.busy", {31'b0, bus.in_ready}, 32'h0);
    issue("mul20", 4'd3, 8'h20, 1, 8'hE0, 8'h00, 0, 0, 1, 0, LATN);
    check("mul20.held_cycles", 32'(last_wait), 32'd8);
`else
    issue("mul03_rsvd", 4'd3, 8'h03, 1, 8'h05, 8'h00, 0, 0, 0, 1, LAT1);
    check("mul03_rsvd.ready", {31'b0, bus.in_ready}, 32'h1);
    issue("div02_rsvd", 4'd4, 8'h02, 1, 8'h05, 8'h00, 0, 0, 0, 1, LAT1);
    issue("clear0", 4'd15, 8'h77, 1, 8'h00, 8'h00, 1, 0, 0, 0, LAT1);
`endif
    issue("loadC8", 4'd14, 8'hC8, 1, 8'hC8, 8'h00, 0, 0, 0, 0, LAT1);
    issue("add64", 4'd1, 8'h64, 1, 8'h2C, 8'h00, 0, 1, 0, 0, LAT1);
    issue("sub2D", 4'd2, 8'h2D, 1, 8'hFF, 8'h00, 0, 1, 0, 0, LAT1);
    issue("subFF", 4'd2, 8'hFF, 1, 8'h00, 8'h00, 1, 0, 0, 0, LAT1);
`ifdef ACCUM_ALU_MULDIV_EN
    issue("load64", 4'd14, 8'h64, 1, 8'h64, 8'h00, 0, 0, 0, 0, LAT1);
    issue("div07", 4'd4, 8'h07, 1, 8'h0E, 8'h02, 0, 0, 0, 0, LATN);
    issue("div00", 4'd4, 8'h00, 1, 8'h0E, 8'h02, 0, 0, 0, 1, LAT1);
    check("div00.ready", {31'b0, bus.in_ready}, 32'h1);
`endif
    issue("clear", 4'd15, 8'h5A, 1, 8'h00, 8'h00, 1, 0, 0, 0, LAT1);
    issue("loadF0", 4'd14, 8'hF0, 1, 8'hF0, 8'h00, 0, 0, 0, 0, LAT1);
    issue("xor3C", 4'd10, 8'h3C, 1, 8'hCC, 8'h00, 0, 0, 0, 0, LAT1);
    issue("not", 4'd7, 8'h00, 1, 8'h33, 8'h00, 0, 0, 0, 0, LAT1);
    issue("nandFF", 4'd11, 8'hFF, 1, 8'hCC, 8'h00, 0, 0, 0, 0, LAT1);
    issue("nor00", 4'd12, 8'h00, 1, 8'h33, 8'h00, 0, 0, 0, 0, LAT1);
    issue("xnor33", 4'd13, 8'h33, 1, 8'hFF, 8'h00, 0, 0, 0, 0, LAT1);
    issue("rsvd5", 4'd5, 8'h12, 1, 8'hFF, 8'h00, 0, 0, 0, 1, LAT1);
    issue("add01_wrap", 4'd1, 8'h01, 1, 8'h00, 8'h00, 1, 1, 0, 1, LAT1);
    issue("nop", 4'd0, 8'h99, 1, 8'h00, 8'h00, 1, 1, 0, 1, LAT1);
    issue("and0F", 4'd8, 8'h0F, 1, 8'h00, 8'h00, 1, 0, 0, 1, LAT1);
    issue("or81", 4'd9, 8'h81, 1, 8'h81, 8'h00, 0, 0, 0, 1, LAT1);
`ifdef ACCUM_ALU_MULDIV_EN
    issue("loadFF", 4'd14, 8'hFF, 1, 8'hFF, 8'h00, 0, 0, 0, 1, LAT1);
    issue("mulFF", 4'd3, 8'hFF, 1, 8'h01, 8'h00, 0, 0, 1, 1, LATN);
    issue("loadFF2", 4'd14, 8'hFF, 1, 8'hFF, 8'h00, 0, 0, 0, 1, LAT1);
    issue("div10", 4'd4, 8'h10, 1, 8'h0F, 8'h0F, 0, 0, 0, 1, LATN);
    issue("clear2", 4'd15, 8'h00, 1, 8'h00, 8'h00, 1, 0, 0, 0, LAT1);
    issue("load05b", 4'd14, 8'h05, 1, 8'h05, 8'h00, 0, 0, 0, 0, LAT1);
    issue("mul_abort", 4'd3, 8'h03, 0, 8'h00, 8'h00, 0, 0, 0, 0, LATN);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.acc", {24'b0, bus.acc}, 32'h0);
    check("abort.in_ready", {31'b0, bus.in_ready}, 32'h1);
    check("abort.done", {31'b0, bus.done}, 32'h0);
    check("abort.zero", {31'b0, bus.zero}, 32'h1);
    check("abort.ovf", {31'b0, bus.ovf}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    issue("load07", 4'd14, 8'h07, 1, 8'h07, 8'h00, 0, 0, 0, 0, LAT1);
`endif
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/accum_alu.md
# accum_alu

Parametrised accumulator ALU, successor to the fixed 4-bit breadboard ALU. It holds a WIDTH-bit accumulator and applies the same 4-bit opcode set against an external operand. Transfers use a valid/ready handshake. MUL and DIV run as iterative multi-cycle operations, and the block reports status flags. It sits between the operand/opcode sequencer and any consumer of the accumulator value.

## Interface
- WIDTH, 8, accumulator and operand width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  opcode/operand offered this cycle
- in_ready  out  1  block can accept; high only in IDLE
- opcode  in  4  operation select
- operand  in  WIDTH  operand A; captured at accept
- acc  out  WIDTH  accumulator value
- rem  out  WIDTH  remainder of last completed DIV
- done  out  1  one-cycle pulse when an accepted op completes
- zero  out  1  acc == 0 after last acc-writing op
- carry  out  1  ADD carry-out / SUB borrow
- ovf  out  1  MUL product exceeded WIDTH bits
- err  out  1  sticky error flag

## Operation
- Accept: in_valid && in_ready at a rising edge; opcode and operand are registered. Later operand changes are ignored.
- Opcodes:
  - 0 NOP: acc unchanged
  - 1 ADD: acc+A
  - 2 SUB: acc−A
  - 3 MUL: low WIDTH bits of acc*A
  - 4 DIV: acc/A, rem = acc%A
  - 5,6 reserved: set err, acc unchanged
  - 7 NOT: ~acc
  - 8 AND, 9 OR, 10 XOR, 11 NAND, 12 NOR, 13 XNOR: acc op A
  - 14 LOAD: acc = A
  - 15 CLEAR: acc = 0, clears err/carry/ovf, rem = 0
- States: IDLE, MUL, DIV.
  - IDLE→MUL on accepted MUL; IDLE→DIV on accepted DIV with A≠0.
  - MUL/DIV→IDLE after WIDTH iteration cycles.
  - All other ops stay in IDLE.
- MUL: shift-add, one bit per cycle. ovf = 1 if upper WIDTH bits of the 2·WIDTH product are nonzero.
- DIV: restoring, one quotient bit per cycle.
- DIV with A=0: single-cycle. err=1; acc, rem unchanged; zero, carry, ovf unchanged.
- Flags:
  - zero is recomputed on every acc-writing op.
  - carry is set by ADD/SUB and cleared by other acc-writing ops.
  - ovf is set by MUL and cleared by other acc-writing ops.
  - NOP and reserved opcodes leave zero, carry and ovf unchanged.
  - err is cleared only by CLEAR or reset.
- Reset values: acc=0, rem=0, done=0, zero=1, carry=0, ovf=0, err=0, state IDLE, in_ready=1.

## Timing
- Single-cycle op accepted at edge N:
  - acc and flags valid after edge N.
  - done high for the cycle following edge N.
  - in_ready stays high, so back-to-back accepts every cycle are legal.
- MUL/DIV accepted at edge N:
  - in_ready low after N.
  - acc, rem and flags update at edge N+WIDTH, where done is also asserted for one cycle.
  - in_ready high again after N+WIDTH, so the next accept is possible at N+WIDTH+1.
- in_valid while in_ready=0: not accepted, no effect. The sequencer holds it until accepted.
- Reset mid-operation aborts the iteration immediately: all outputs return to reset values, and no done pulse is emitted for the aborted op.
- Arithmetic is modulo 2^WIDTH; all values are unsigned.

## Configuration
- ACCUM_ALU_MULDIV_EN defined: MUL/DIV iterative datapath and MUL/DIV states are built as above.
- Undefined:
  - No multiplier/divider logic is built.
  - Opcodes 3 and 4 behave as reserved: single cycle, err=1, acc unchanged, done pulses.
  - ovf is tied 0; rem holds 0.

## Test plan
WIDTH=8, macro defined unless noted.
- Reset, LOAD 0x05, MUL 0x03 → in_ready low 8 cycles; acc=0x0F, ovf=0, single done pulse at edge N+8. Then MUL 0x20 → acc=0xE0, ovf=1.
- LOAD 0xC8, ADD 0x64 → acc=0x2C, carry=1, zero=0. SUB 0x2D → acc=0xFF, carry=1. SUB 0xFF → acc=0x00, zero=1, carry=0.
- LOAD 0x64, DIV 0x07 → after 8 cycles acc=0x0E, rem=0x02. DIV 0x00 → err=1, acc=0x0E, done one cycle later, in_ready never drops. CLEAR → err=0, acc=0.
- LOAD 0xF0, XOR 0x3C → 0xCC; NOT → 0x33; NAND 0xFF → 0xCC; NOR 0x00 → 0x33; XNOR 0x33 → 0xFF; opcode 5 → err=1, acc=0xFF.
- Start MUL, assert rst low on iteration cycle 3 → acc=0, in_ready=1, no done. in_valid held high during busy cycles is not accepted until in_ready returns.
- Macro undefined: LOAD 0x05, MUL 0x03 → done after 1 cycle, err=1, acc=0x05, ovf=0.
